// File: rtl/tone_pkg.sv
// Shared constants for the tone oscillator/decoder pair: note divisor table,
// derived nominal periods and the decoder FSM state encoding.
package tone_pkg;

   localparam int NOTE_W    = 3;
   localparam int PERIOD_W  = 17;
   localparam int NUM_NOTES = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   // Same divisors the oscillator counts to; one tone period is divisor + 1 cycles.
   function automatic logic [PERIOD_W-1:0] divisor(input logic [NOTE_W-1:0] n);
      logic [PERIOD_W-1:0] d;
      d = '0;
      case (n)
         3'd0: d = 17'd45801;
         3'd1: d = 17'd40805;
         3'd2: d = 17'd36352;
         3'd3: d = 17'd34312;
         3'd4: d = 17'd30569;
         3'd5: d = 17'd27234;
         3'd6: d = 17'd24263;
         3'd7: d = 17'd22901;
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [PERIOD_W-1:0] nominal_period(input logic [NOTE_W-1:0] n);
      return divisor(n) + 17'd1;
   endfunction

   function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                    input logic [PERIOD_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for the asynchronous tone input plus a delay flop,
// producing a one-cycle pulse on each synchronized rising edge.
module tone_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // NOTE: non-blocking assignments make the three flops a true shift chain;
   // blocking ones would collapse it to a single flop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_din;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone between rising edges, classifies it
// as one of eight scale notes and reports a note once it is stable.
module tone_decoder
   import tone_pkg::*;
#(
   parameter int TOL          = 512,
   parameter int STABLE_COUNT = 2,
   parameter int TIMEOUT      = 65536
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              TONE_IN,
   output logic [NOTE_W-1:0] NOTE,
   output logic              VALID,
   output logic              NOTE_STB
);

   localparam logic [PERIOD_W-1:0] TOL_V     = PERIOD_W'(TOL);
   localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
   localparam logic [3:0]          STABLE_V  = 4'(STABLE_COUNT);

   logic                w_rise;
   logic                w_hit;
   logic [NOTE_W-1:0]   w_hit_note;
   logic [3:0]          w_acq_cnt;
   logic [3:0]          w_seed_cnt;
   logic                w_timeout;

   state_t              r_state;
   logic [PERIOD_W-1:0] r_count;
   logic [NOTE_W-1:0]   r_cand;
   logic [3:0]          r_match_cnt;

   tone_sync_edge u_sync (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_din  (TONE_IN),
      .o_rise (w_rise)
   );

   // r_count holds the measured period P in the cycle w_rise is high.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_note = '0;
      for (int n = 0; n < NUM_NOTES; n++) begin
         if (abs_diff(r_count, nominal_period(NOTE_W'(n))) <= TOL_V) begin
            w_hit      = 1'b1;
            w_hit_note = NOTE_W'(n);
         end
      end
   end

   assign w_acq_cnt  = !w_hit ? 4'd0 :
                       (w_hit_note == r_cand && r_match_cnt != 4'd0) ? r_match_cnt + 4'd1 : 4'd1;
   assign w_seed_cnt = w_hit ? 4'd1 : 4'd0;
   assign w_timeout  = (r_count == TIMEOUT_V);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_cand      <= '0;
         r_match_cnt <= '0;
         NOTE        <= '0;
         VALID       <= 1'b0;
         NOTE_STB    <= 1'b0;
      end else begin
         NOTE_STB <= 1'b0;
         if (w_rise)
            r_count <= PERIOD_W'(1);
         else if (r_count != '1)
            r_count <= r_count + PERIOD_W'(1);

         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state     <= ST_ACQUIRE;
                  r_match_cnt <= '0;
               end
            end
            ST_ACQUIRE: begin
               if (w_rise) begin
                  if (w_hit) r_cand <= w_hit_note;
                  r_match_cnt <= w_acq_cnt;
                  if (w_acq_cnt == STABLE_V) begin
                     r_state  <= ST_LOCKED;
                     NOTE     <= w_hit_note;
                     VALID    <= 1'b1;
                     NOTE_STB <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_match_cnt <= '0;
               end
            end
            ST_LOCKED: begin
               if (w_rise) begin
                  if (!(w_hit && w_hit_note == NOTE)) begin
                     if (w_hit) r_cand <= w_hit_note;
                     r_match_cnt <= w_seed_cnt;
                     // A single stable period is enough to relock when STABLE_COUNT is 1.
                     if (w_seed_cnt == STABLE_V) begin
                        NOTE     <= w_hit_note;
                        NOTE_STB <= 1'b1;
                     end else begin
                        r_state <= ST_ACQUIRE;
                        VALID   <= 1'b0;
                     end
                  end
               end else if (w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_match_cnt <= '0;
                  VALID       <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
